// File: rtl/preproc_str_tx.sv
// Serializes a NUL-left-padded packed ASCII string onto a valid/ready byte stream.
// Leading NUL padding is skipped; the first character goes out first.
module preproc_str_tx #(
  parameter int unsigned MAX_CHARS = 80,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*MAX_CHARS-1:0]   str_in,
  input  logic                     start,
  output logic                     busy,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done,
  output logic                     empty,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

  state_t                         state_q, state_d;
  logic [MAX_CHARS-1:0][7:0]      cap_q, cap_d;
  logic [IDX_W-1:0]               idx_q, idx_d, idx_dec;
  logic                           primed_q, primed_d;
  logic [7:0]                     cur_byte, next_byte;
  logic [7:0]                     out_data_d;
  logic                           out_valid_d, out_last_d, done_d, empty_d, busy_d;
  logic [CNT_W-1:0]               count_d;

  assign idx_dec   = idx_q - IDX_W'(1);
  assign cur_byte  = cap_q[idx_q];
  assign next_byte = cap_q[idx_dec];

  // State, capture and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      idx_q     <= '0;
      primed_q  <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      empty     <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      idx_q     <= idx_d;
      primed_q  <= primed_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      done      <= done_d;
      empty     <= empty_d;
      busy      <= busy_d;
      count     <= count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    primed_d    = primed_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    done_d      = 1'b0;
    empty_d     = 1'b0;
    count_d     = count;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d    = str_in;
          idx_d    = IDX_W'(MAX_CHARS - 1);
          count_d  = '0;
          primed_d = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // First SCAN cycle only arms the scan so the captured copy is settled
        if (!primed_q) begin
          primed_d = 1'b1;
        end else if (cur_byte != 8'h00) begin
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_data_d  = cur_byte;
          out_last_d  = (idx_q == '0);
        end else if (idx_q != '0) begin
          idx_d = idx_dec;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          empty_d = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          count_d = count + CNT_W'(1);
          if (idx_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_dec;
            out_data_d = next_byte;
            out_last_d = (idx_dec == '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_preproc_str_tx.sv
// Directed bench for preproc_str_tx with MAX_CHARS=8: latency, streaming,
// stalls, NUL handling, start-while-busy and mid-transfer reset.
module tb_preproc_str_tx;

  localparam int unsigned MAX_CHARS = 8;
  localparam int unsigned CNT_W     = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [8*MAX_CHARS-1:0] str_in;
  logic                   start;
  logic                   busy;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   done;
  logic                   empty;
  logic [CNT_W-1:0]       count;

  preproc_str_tx #(.MAX_CHARS(MAX_CHARS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .str_in(str_in), .start(start), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] STR_HELLO = {24'h000000, 40'h68656c6c6f};
  localparam logic [63:0] STR_EMB   = {8'h41, 8'h00, 8'h42, 40'h0};
  localparam logic [63:0] STR_ABC   = {40'h0, 24'h616263};
  localparam logic [63:0] STR_OTHER = 64'h574f524c44212121;

  logic [7:0] exp_hello [5] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
  logic [7:0] exp_emb   [8] = '{8'h41, 8'h00, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_abc   [3] = '{8'h61, 8'h62, 8'h63};

  // Results of the most recent transfer
  logic [7:0]       got_data [16];
  logic             got_last [16];
  int               got_n, first_vld, done_cyc, stall_err;
  logic             timed_out, got_empty;
  logic [CNT_W-1:0] got_count;

  // Starts a transfer and records the stream until done (bounded). mode 0:
  // ready always high, mode 1: ready high one cycle in three. mid_c pulses
  // start with str_in=s2 at that cycle.
  task automatic run_xfer(input logic [63:0] s, input int mode, input int mid_c,
                          input logic [63:0] s2);
    logic       pv, pr, pl;
    logic [7:0] pd;
    got_n = 0; first_vld = -1; done_cyc = -1; stall_err = 0;
    timed_out = 1'b1; got_empty = 1'b0; got_count = '0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; pl = 1'b0;
    @(negedge clk); str_in = s; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == mid_c);
      if (start) str_in = s2;
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && first_vld < 0) first_vld = c;
      if (out_valid && out_ready && got_n < 16) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_n++;
      end
      if (done) begin
        done_cyc = c; got_empty = empty; got_count = count; timed_out = 1'b0;
        break;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; str_in = STR_HELLO;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, out_valid, out_last, done, empty} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, out_valid, out_last, done, empty});
    end
    n_checks++;
    if (out_data !== 8'h00 || count !== '0) begin
      n_fail++; $display("FAIL reset_data_count: got data=%0h count=%0d expected 0/0", out_data, count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_xfer(STR_HELLO, 0, -1, '0);
    n_checks++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", timed_out); end
    n_checks++;
    if (first_vld != 5) begin n_fail++; $display("FAIL basic_first_valid: got %0d expected 5", first_vld); end
    n_checks++;
    if (got_n != 5) begin n_fail++; $display("FAIL basic_len: got %0d expected 5", got_n); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_data[i] !== exp_hello[i] || got_last[i] !== (i == 4)) begin
        n_fail++; $display("FAIL basic_byte%0d: got %0h/last=%b expected %0h/last=%b", i, got_data[i], got_last[i], exp_hello[i], (i == 4));
      end
    end
    n_checks++;
    if (done_cyc != 10 || got_empty !== 1'b0 || got_count !== 4'd5) begin
      n_fail++; $display("FAIL basic_done: got cyc=%0d empty=%b count=%0d expected 10/0/5", done_cyc, got_empty, got_count);
    end
  endtask

  task automatic test_stall();
    run_xfer(STR_HELLO, 1, -1, '0);
    n_checks++;
    if (timed_out !== 1'b0 || got_n != 5) begin
      n_fail++; $display("FAIL stall_len: got n=%0d timeout=%b expected 5/0", got_n, timed_out);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_data[i] !== exp_hello[i] || got_last[i] !== (i == 4)) begin
        n_fail++; $display("FAIL stall_byte%0d: got %0h/last=%b expected %0h/last=%b", i, got_data[i], got_last[i], exp_hello[i], (i == 4));
      end
    end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d violations expected 0", stall_err); end
    n_checks++;
    if (got_count !== 4'd5 || got_empty !== 1'b0) begin
      n_fail++; $display("FAIL stall_count: got count=%0d empty=%b expected 5/0", got_count, got_empty);
    end
  endtask

  task automatic test_all_nul();
    run_xfer(64'h0, 0, -1, '0);
    n_checks++;
    if (first_vld != -1 || got_n != 0) begin
      n_fail++; $display("FAIL nul_no_valid: got first=%0d n=%0d expected -1/0", first_vld, got_n);
    end
    n_checks++;
    if (done_cyc != 9 || got_empty !== 1'b1 || got_count !== 4'd0) begin
      n_fail++; $display("FAIL nul_done: got cyc=%0d empty=%b count=%0d expected 9/1/0", done_cyc, got_empty, got_count);
    end
  endtask

  task automatic test_embedded_nul();
    run_xfer(STR_EMB, 0, -1, '0);
    n_checks++;
    if (first_vld != 2 || got_n != 8) begin
      n_fail++; $display("FAIL emb_len: got first=%0d n=%0d expected 2/8", first_vld, got_n);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_data[i] !== exp_emb[i] || got_last[i] !== (i == 7)) begin
        n_fail++; $display("FAIL emb_byte%0d: got %0h/last=%b expected %0h/last=%b", i, got_data[i], got_last[i], exp_emb[i], (i == 7));
      end
    end
    n_checks++;
    if (done_cyc != 10 || got_count !== 4'd8 || got_empty !== 1'b0) begin
      n_fail++; $display("FAIL emb_done: got cyc=%0d count=%0d empty=%b expected 10/8/0", done_cyc, got_count, got_empty);
    end
  endtask

  task automatic test_back_to_back();
    // start during SEND with a new string must not disturb the transfer
    run_xfer(STR_HELLO, 0, 7, STR_OTHER);
    n_checks++;
    if (got_n != 5 || got_count !== 4'd5) begin
      n_fail++; $display("FAIL b2b_len: got n=%0d count=%0d expected 5/5", got_n, got_count);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_data[i] !== exp_hello[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %0h expected %0h", i, got_data[i], exp_hello[i]);
      end
    end
    // Immediately restart in the first IDLE cycle after done
    run_xfer(STR_ABC, 0, -1, '0);
    n_checks++;
    if (first_vld != 7 || got_n != 3 || done_cyc != 10 || got_count !== 4'd3) begin
      n_fail++; $display("FAIL b2b_restart: got first=%0d n=%0d cyc=%0d count=%0d expected 7/3/10/3", first_vld, got_n, done_cyc, got_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_data[i] !== exp_abc[i] || got_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL b2b_abc%0d: got %0h/last=%b expected %0h/last=%b", i, got_data[i], got_last[i], exp_abc[i], (i == 2));
      end
    end
    // start while done is high is ignored
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_idle: got busy=%b expected 0", busy); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ignored: got busy=%b valid=%b expected 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    @(negedge clk); str_in = STR_HELLO; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_data == 8'h6c) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: got %b expected 1", found); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || count !== '0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state: got valid=%b busy=%b count=%0d last=%b expected 0/0/0/0", out_valid, busy, count, out_last);
    end
    run_xfer(STR_HELLO, 0, -1, '0);
    n_checks++;
    if (got_n != 5 || got_count !== 4'd5 || first_vld != 5) begin
      n_fail++; $display("FAIL rst_replay_len: got n=%0d count=%0d first=%0d expected 5/5/5", got_n, got_count, first_vld);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_data[i] !== exp_hello[i]) begin
        n_fail++; $display("FAIL rst_replay_byte%0d: got %0h expected %0h", i, got_data[i], exp_hello[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_all_nul();
    test_embedded_nul();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
